// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad controller.
package keypad_pkg;

  localparam int ROW_W = 2;
  localparam int COL_W = 2;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_PRESS_DB,
    ST_PRESSED,
    ST_HOLD,
    ST_REL_DB
  } kp_state_e;

  // Indexed [row][col].
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Lowest-index row pulled low; rows are active-low.
  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [3:0] rows);
    lowest_low_row = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) lowest_low_row = ROW_W'(i);
    end
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous keypad row inputs.
module sync2 #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_ctrl.sv
// 4x4 keypad scanner: column scan, press/release debounce, key decode.
// dbg_state exposes the FSM state for checkers.
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic [3:0] row_d,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic      key_valid,
  output logic      key_held,
  output kp_state_e dbg_state
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);

  logic [3:0]       row_s;
  kp_state_e        state_q, state_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]       key_code_q, key_code_d;

  sync2 #(.W(4), .RST_VAL(4'hF)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_d),
    .q   (row_s)
  );

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    dwell_d    = dwell_q;
    db_cnt_d   = db_cnt_q;
    key_code_d = key_code_q;
    case (state_q)
      ST_SCAN: begin
        // Sampling only on the last dwell cycle lets the synchronizer settle.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_s != 4'hF) begin
            row_idx_d = lowest_low_row(row_s);
            db_cnt_d  = '0;
            state_d   = ST_PRESS_DB;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_PRESS_DB: begin
        if (row_s[row_idx_q]) begin
          dwell_d = '0;
          state_d = ST_SCAN;
        end else if (db_cnt_q == DB_LAST) begin
          key_code_d = KEY_MAP[row_idx_q][col_idx_q];
          state_d    = ST_PRESSED;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_PRESSED: state_d = ST_HOLD;
      ST_HOLD: begin
        if (row_s[row_idx_q]) begin
          db_cnt_d = '0;
          state_d  = ST_REL_DB;
        end
      end
      ST_REL_DB: begin
        if (!row_s[row_idx_q]) begin
          state_d = ST_HOLD;
        end else if (db_cnt_q == DB_LAST) begin
          col_idx_d = col_idx_q + 1'b1;
          dwell_d   = '0;
          state_d   = ST_SCAN;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      col_idx_q  <= '0;
      row_idx_q  <= '0;
      dwell_q    <= '0;
      db_cnt_q   <= '0;
      key_code_q <= '0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      dwell_q    <= dwell_d;
      db_cnt_q   <= db_cnt_d;
      key_code_q <= key_code_d;
    end
  end

  // col_idx_q is frozen outside SCAN, so the drive stays on the latched column.
  assign col_out   = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = (state_q == ST_PRESSED);
  assign key_held  = (state_q == ST_HOLD) || (state_q == ST_REL_DB);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// Bench for keypad_ctrl: physical keypad model driving rows from the column drive,
// directed scenarios plus random key activity checked against a reference model.
module tb_keypad_ctrl;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0] row_d;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  kp_state_e  dbg_state;

  always #5 clk = ~clk;

  keypad_ctrl #(.SCAN_DIV(SD), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_d     (row_d),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .dbg_state (dbg_state)
  );

  // A closed key at (r,c) pulls row r low only while column c is driven low.
  function automatic logic [3:0] rows_of(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (k[r*4+cc] && !c[cc]) rows[r] = 1'b0;
    return rows;
  endfunction

  assign row_d = rows_of(keys, col_out);

  int total = 0;
  int bad = 0;
  int dut_strobes = 0;
  logic [3:0] exp_q[$];

  // Reference model: phase 0 scan, 1 press debounce, 2 strobe, 3 hold, 4 release debounce.
  int         m_phase, m_base, m_t, m_cnt;
  logic [1:0] m_col, m_row;
  logic [3:0] m_code;
  logic [3:0] sq[$];
  int key_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  function automatic int m_cur_col();
    return (m_phase == 0) ? (m_base + m_t / SD) % 4 : int'(m_col);
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rd);
    logic [3:0] rs;
    if (r) begin
      m_phase = 0; m_base = 0; m_t = 0; m_cnt = 0;
      m_col = 2'd0; m_row = 2'd0; m_code = 4'h0;
      sq.delete(); sq.push_back(4'hF); sq.push_back(4'hF);
      return;
    end
    rs = sq.pop_front();
    sq.push_back(rd);
    case (m_phase)
      0: begin
        if ((m_t % SD == SD - 1) && rs != 4'hF) begin
          m_col = 2'(m_cur_col());
          for (int i = 3; i >= 0; i--) if (!rs[i]) m_row = 2'(i);
          m_phase = 1;
          m_cnt = 0;
        end else begin
          m_t++;
          if (m_t == 4 * SD) m_t = 0;
        end
      end
      1: begin
        if (rs[m_row]) begin
          m_phase = 0; m_base = int'(m_col); m_t = 0;
        end else if (m_cnt == DB - 1) begin
          m_phase = 2;
          m_code = 4'(key_tab[{m_row, m_col}]);
          exp_q.push_back(m_code);
        end else m_cnt++;
      end
      2: m_phase = 3;
      3: if (rs[m_row]) begin m_phase = 4; m_cnt = 0; end
      4: begin
        if (!rs[m_row]) m_phase = 3;
        else if (m_cnt == DB - 1) begin
          m_phase = 0; m_base = (int'(m_col) + 1) % 4; m_t = 0;
        end else m_cnt++;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: sample inputs, advance one clock, compare at the next negedge.
  task automatic tick();
    logic       r;
    logic [3:0] rd;
    logic [3:0] exp_col;
    #1;
    r = rst;
    rd = row_d;
    @(posedge clk);
    model_step(r, rd);
    @(negedge clk);
    exp_col = ~(4'b0001 << m_cur_col());
    check("col_out", col_out, exp_col);
    check("key_valid", {3'b000, key_valid}, {3'b000, (m_phase == 2)});
    check("key_held", {3'b000, key_held}, {3'b000, (m_phase == 3 || m_phase == 4)});
    check("key_code", key_code, m_code);
    if (key_valid === 1'b1) begin
      dut_strobes++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_strobe observed=%h expected=none", key_code);
      end
      if (exp_q.size() != 0) check("strobe_code", key_code, exp_q.pop_front());
    end
  endtask

  task automatic wait_scan_col(input int c, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == 0 && m_cur_col() == c && m_t % SD == 0) begin
        found = 1;
        break;
      end
      tick();
    end
    check_int("wait_scan_col", int'(found), 1);
  endtask

  task automatic wait_press_db(input int cnt, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == 1 && m_cnt == cnt) begin
        found = 1;
        break;
      end
      tick();
    end
    check_int("wait_press_db", int'(found), 1);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    keys = '0;
    @(negedge clk);
    repeat (3) tick();
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", {3'b000, key_valid}, 4'h0);
    check("rst_key_held", {3'b000, key_held}, 4'h0);
    rst = 1'b0;

    // Idle scanning
    dut_strobes = 0;
    repeat (40) tick();
    check_int("idle_strobes", dut_strobes, 0);

    // Clean press of "8" (row 2, col 1)
    wait_scan_col(1, 40);
    dut_strobes = 0;
    keys[2*4+1] = 1'b1;
    repeat (30) tick();
    check("press8_code", key_code, 4'h8);
    check("press8_held", {3'b000, key_held}, 4'h1);
    keys = '0;
    repeat (30) tick();
    check_int("press8_strobes", dut_strobes, 1);
    check("press8_released", {3'b000, key_held}, 4'h0);

    // Bounce on row 1 / col 0 shorter than the debounce window
    wait_scan_col(0, 40);
    dut_strobes = 0;
    keys[1*4+0] = 1'b1;
    repeat (3) tick();
    keys = '0;
    repeat (3) tick();
    check("bounce_col_out", col_out, 4'b1110);
    repeat (20) tick();
    check_int("bounce_strobes", dut_strobes, 0);

    // Release bounce on "5" (row 1, col 1)
    wait_scan_col(1, 40);
    dut_strobes = 0;
    keys[1*4+1] = 1'b1;
    repeat (20) tick();
    keys[1*4+1] = 1'b0;
    repeat (3) tick();
    keys[1*4+1] = 1'b1;
    repeat (5) tick();
    check("rel_bounce_held", {3'b000, key_held}, 4'h1);
    keys[1*4+1] = 1'b0;
    repeat (20) tick();
    check_int("rel_bounce_strobes", dut_strobes, 1);
    check("rel_bounce_code", key_code, 4'h5);

    // Second key "D" pressed while "1" is held
    wait_scan_col(0, 40);
    dut_strobes = 0;
    keys[0] = 1'b1;
    repeat (20) tick();
    keys[3*4+3] = 1'b1;
    repeat (20) tick();
    check_int("two_key_strobes_a", dut_strobes, 1);
    check("two_key_code_a", key_code, 4'h1);
    keys[0] = 1'b0;
    repeat (50) tick();
    keys = '0;
    repeat (20) tick();
    check_int("two_key_strobes_b", dut_strobes, 2);
    check("two_key_code_b", key_code, 4'hD);

    // Reset in the middle of a press debounce on "9"
    wait_scan_col(2, 40);
    dut_strobes = 0;
    keys[2*4+2] = 1'b1;
    wait_press_db(4, 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_col_out", col_out, 4'b1110);
    check("mid_rst_key_valid", {3'b000, key_valid}, 4'h0);
    check("mid_rst_key_code", key_code, 4'h0);
    keys = '0;
    repeat (20) tick();
    check_int("mid_rst_strobes", dut_strobes, 0);

    // Random key activity with occasional reset
    repeat (800) begin
      if ($urandom_range(0, 9) == 0) keys = keys ^ (16'h0001 << $urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    keys = '0;
    repeat (40) tick();
    check_int("pending_strobes", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
